// File: rtl/alu_rs.sv
// Integer ALU reservation station: collapsing age-ordered queue with CDB wakeup
// and a registered issue slot feeding the single-cycle ALU.
package core_pkg;
  localparam int XLEN       = 32;
  localparam int LOG2_PREGS = 6;
endpackage

module alu_rs #(
  parameter int XLEN    = core_pkg::XLEN,
  parameter int PHYS_W  = core_pkg::LOG2_PREGS,
  parameter int ENTRIES = 8,
  parameter int ROB_W   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [7:0]                     dispatch_op,
  input  logic [PHYS_W-1:0]              dispatch_dst_tag,
  input  logic [PHYS_W-1:0]              dispatch_src1_tag,
  input  logic [PHYS_W-1:0]              dispatch_src2_tag,
  input  logic                           dispatch_src1_rdy,
  input  logic                           dispatch_src2_rdy,
  input  logic [XLEN-1:0]                dispatch_src1_val,
  input  logic [XLEN-1:0]                dispatch_src2_val,
  input  logic [ROB_W-1:0]               dispatch_rob_tag,
  input  logic                           cdb_valid,
  input  logic [PHYS_W-1:0]              cdb_tag,
  input  logic [XLEN-1:0]                cdb_value,
  input  logic                           issue_ready,
  output logic                           issue_valid,
  output logic [7:0]                     issue_op,
  output logic [PHYS_W-1:0]              issue_dst_tag,
  output logic [XLEN-1:0]                issue_src1_val,
  output logic [XLEN-1:0]                issue_src2_val,
  output logic [ROB_W-1:0]               issue_rob_tag,
  output logic [$clog2(ENTRIES+1)-1:0]   count
);
  localparam int CW = $clog2(ENTRIES+1);

  typedef struct packed {
    logic [7:0]        op;
    logic [PHYS_W-1:0] dst;
    logic [PHYS_W-1:0] t1;
    logic              r1;
    logic [XLEN-1:0]   v1;
    logic [PHYS_W-1:0] t2;
    logic              r2;
    logic [XLEN-1:0]   v2;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t          q     [ENTRIES];
  entry_t          q_wk  [ENTRIES];
  entry_t          q_nxt [ENTRIES];
  entry_t          new_e;
  entry_t          sel_e;
  logic            sel_found;
  logic [CW-1:0]   sel_idx;
  logic [CW-1:0]   wr_idx;
  logic [CW-1:0]   count_nxt;
  logic            load;
  logic            do_issue;
  logic            do_disp;

  assign dispatch_ready = (count < CW'(ENTRIES));
  assign load           = !issue_valid || issue_ready;
  assign do_disp        = dispatch_valid && dispatch_ready;
  assign do_issue       = load && sel_found;
  assign wr_idx         = count - CW'(do_issue);
  assign count_nxt      = count + CW'(do_disp) - CW'(do_issue);

  // Incoming entry picks up a same-cycle CDB broadcast for any source still pending.
  always_comb begin
    new_e     = '0;
    new_e.op  = dispatch_op;
    new_e.dst = dispatch_dst_tag;
    new_e.t1  = dispatch_src1_tag;
    new_e.r1  = dispatch_src1_rdy;
    new_e.v1  = dispatch_src1_val;
    new_e.t2  = dispatch_src2_tag;
    new_e.r2  = dispatch_src2_rdy;
    new_e.v2  = dispatch_src2_val;
    new_e.rob = dispatch_rob_tag;
    if (!dispatch_src1_rdy && cdb_valid && cdb_tag == dispatch_src1_tag) begin
      new_e.r1 = 1'b1;
      new_e.v1 = cdb_value;
    end
    if (!dispatch_src2_rdy && cdb_valid && cdb_tag == dispatch_src2_tag) begin
      new_e.r2 = 1'b1;
      new_e.v2 = cdb_value;
    end
  end

  // Select looks at registered readiness, so a wakeup costs one edge before issue.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_e     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!sel_found && CW'(i) < count && q[i].r1 && q[i].r2) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
        sel_e     = q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      q_wk[i] = q[i];
      if (!q[i].r1 && cdb_valid && cdb_tag == q[i].t1) begin
        q_wk[i].r1 = 1'b1;
        q_wk[i].v1 = cdb_value;
      end
      if (!q[i].r2 && cdb_valid && cdb_tag == q[i].t2) begin
        q_wk[i].r2 = 1'b1;
        q_wk[i].v2 = cdb_value;
      end
    end
  end

  // Collapse above the issued entry, then append the dispatch at the new tail.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) q_nxt[i] = q_wk[i];
    for (int i = 0; i < ENTRIES-1; i++) begin
      if (do_issue && CW'(i) >= sel_idx) q_nxt[i] = q_wk[i+1];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (do_disp && CW'(i) == wr_idx) q_nxt[i] = new_e;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      issue_valid    <= 1'b0;
      issue_op       <= '0;
      issue_dst_tag  <= '0;
      issue_src1_val <= '0;
      issue_src2_val <= '0;
      issue_rob_tag  <= '0;
      for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
    end else if (flush) begin
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      count <= count_nxt;
      for (int i = 0; i < ENTRIES; i++) q[i] <= q_nxt[i];
      if (load) begin
        issue_valid <= sel_found;
        if (sel_found) begin
          issue_op       <= sel_e.op;
          issue_dst_tag  <= sel_e.dst;
          issue_src1_val <= sel_e.v1;
          issue_src2_val <= sel_e.v2;
          issue_rob_tag  <= sel_e.rob;
        end
      end
    end
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU. Holds up to ENTRIES dispatched ALU micro-ops and captures source operands from the CDB as they become available. Each cycle it selects the oldest entry whose operands are both ready and loads it into a registered issue slot. That slot drives the ALU's `issue_*` inputs directly. It sits between rename/dispatch and the 1-cycle ALU.

## Interface
- XLEN, default core_pkg::XLEN: data width.
- PHYS_W, default core_pkg::LOG2_PREGS: physical register tag width.
- ENTRIES, default 8: queue depth, at least 2.
- ROB_W, default 6: ROB tag width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all contents.
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  space available; equals `count < ENTRIES`; must not depend on dispatch_valid.
- dispatch_op  in  8  ALU op code, passed through unchanged.
- dispatch_dst_tag  in  PHYS_W  destination physical register.
- dispatch_src1_tag, dispatch_src2_tag  in  PHYS_W  source tags.
- dispatch_src1_rdy, dispatch_src2_rdy  in  1  source value already valid.
- dispatch_src1_val, dispatch_src2_val  in  XLEN  source values; immediates arrive as src2 with rdy=1.
- dispatch_rob_tag  in  ROB_W  ROB index.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  PHYS_W  CDB broadcast tag.
- cdb_value  in  XLEN  CDB broadcast value.
- issue_ready  in  1  consumer accepts the issue slot this cycle.
- issue_valid  out  1  issue slot holds a micro-op.
- issue_op  out  8  issue slot op code.
- issue_dst_tag  out  PHYS_W  issue slot destination tag.
- issue_src1_val, issue_src2_val  out  XLEN  issue slot operand values.
- issue_rob_tag  out  ROB_W  issue slot ROB index.
- count  out  $clog2(ENTRIES+1)  current number of occupied entries.

## Operation
- Storage is a collapsing queue: entry 0 is always the oldest, valid entries are contiguous from 0, and entries never reorder.
- Per-entry fields: valid, op, dst, src1/src2 tag, rdy and val, rob.
- Dispatch fires when `dispatch_valid && dispatch_ready`.
  - The new entry is written at position `count` after any same-cycle collapse.
- Wakeup: for every valid entry and each source with `rdy=0`, a CDB match (`cdb_valid && cdb_tag == src_tag`) sets rdy=1 and val=cdb_value at the edge.
- Dispatch bypass: a dispatching source with `rdy=0` whose tag matches the CDB in the same cycle is written with rdy=1 and val=cdb_value.
- Select: the lowest-index valid entry with both rdy=1.
- Issue slot load condition: `!issue_valid || issue_ready`.
  - If the load condition holds and a selected entry exists, the slot is loaded from that entry, the entry is removed, and higher entries shift down by one.
  - If the load condition holds and no entry is selected, issue_valid goes to 0.
  - If `issue_valid && !issue_ready`, the slot holds all fields unchanged.
- Simultaneous dispatch and issue: count is unchanged and the new entry lands at `count-1`.
- Full: dispatch_ready=0 and dispatch_valid is ignored. An issue in the same cycle frees space only from the next cycle.
- Empty: select finds nothing and no issue occurs.
- flush has priority over dispatch, wakeup and issue.
  - Next cycle: all entries invalid, count=0, issue_valid=0.
  - A dispatch in the flush cycle is dropped.
- Reset mid-operation: immediate return to reset state; in-flight contents are lost.

## Timing
- Reset values: issue_valid=0, issue_op=0, issue_dst_tag=0, issue_src1_val=0, issue_src2_val=0, issue_rob_tag=0, count=0.
- dispatch_ready=1 during and after reset, since it is combinational from count=0.
- Minimum latency, dispatch to issue_valid: dispatch at edge N with both sources ready, selected in cycle N, issue_valid=1 after edge N+1.
- Wakeup latency: CDB match in cycle N gives rdy=1 after edge N, so the earliest issue_valid is after edge N+1.
  - The same holds for the dispatch-bypass case.
- Throughput: one issue per cycle while issue_ready=1 and ready entries exist.
- issue_* are driven only from flops; no combinational path from dispatch_* or cdb_* to issue_*.

## Test plan
- Back-to-back ready ops:
  - Stimulus: dispatch ADDI (op=0x20, src1=5, src2=3, rob=1), then ADDI (src1=7, src2=1, rob=2) on consecutive cycles, issue_ready=1.
  - Response: issue_valid on two consecutive cycles with rob 1 then 2; count returns to 0.
- Wakeup ordering:
  - Stimulus: dispatch A (src1 tag 9, rdy=0, rob=3), then B (both ready, rob=4). Next cycle CDB tag 9, value 0x1234.
  - Response: B issues first; A issues the cycle after the CDB, with issue_src1_val=0x1234.
- Dispatch bypass:
  - Stimulus: dispatch with src2 tag 12, rdy=0, while cdb_valid with tag 12 and value 0xFF.
  - Response: issues after 2 edges with issue_src2_val=0xFF.
- Full and stall:
  - Stimulus: fill 8 entries with issue_ready=0.
  - Response: dispatch_ready=0, count=8, a 9th dispatch is ignored, and the issue slot holds its fields unchanged. Raising issue_ready then drains the queue in age order.
- Flush:
  - Stimulus: with count=5 and issue_valid=1, assert flush together with dispatch_valid.
  - Response: next cycle count=0, issue_valid=0, and the flushed dispatch never issues.
- Async reset:
  - Stimulus: assert reset mid-cycle with count=3.
  - Response: outputs go to their reset values immediately, without waiting for clk.
